// File: rtl/cmd_dispatcher_pkg.sv
// Shared definitions for the command dispatcher: opcode values, FSM state
// encoding, status-byte bit positions and small decode helpers.
package cmd_dispatcher_pkg;

  localparam logic [7:0] OpGetAdc     = 8'h01;
  localparam logic [7:0] OpSetPwmBase = 8'h10;  // 0x10 + channel
  localparam logic [7:0] OpPwmOn      = 8'h20;
  localparam logic [7:0] OpPwmOff     = 8'h21;
  localparam logic [7:0] OpGetStatus  = 8'h30;
  localparam logic [7:0] OpClrErr     = 8'h31;

  localparam int unsigned StatusPwmOnBit = 0;
  localparam int unsigned StatusErrBit   = 1;

  typedef enum logic [2:0] {
    StIdle,
    StArg,
    StAdcReq,
    StAdcWait,
    StAdcTx,
    StStatTx
  } state_e;

  // True for the whole 0x1k block; channel range is checked by the caller.
  function automatic logic is_set_pwm(logic [7:0] op);
    return op[7:4] == OpSetPwmBase[7:4];
  endfunction

  function automatic logic [7:0] status_byte(logic err, logic pwm_on);
    logic [7:0] s;
    s                 = '0;
    s[StatusErrBit]   = err;
    s[StatusPwmOnBit] = pwm_on;
    return s;
  endfunction

endpackage

// File: rtl/cmd_dispatcher_if.sv
// Bus bundle between the command dispatcher and its surroundings.
//   rx_*  : read side of the command rx FIFO (first-word-fall-through)
//   tx_*  : write side of the response tx FIFO
//   adc_* : start/busy/data handshake to the ADC interface
// master = dispatcher side, slave = FIFO/ADC side.
interface cmd_dispatcher_if #(
  parameter int unsigned AdcBytes = 4
);
  logic [7:0]            rx_rdata;
  logic                  rx_rempty;
  logic                  rx_rinc;
  logic [7:0]            tx_wdata;
  logic                  tx_winc;
  logic                  tx_wfull;
  logic                  adc_start;
  logic                  adc_busy;
  logic [8*AdcBytes-1:0] adc_data;

  modport master (
    input  rx_rdata, rx_rempty, tx_wfull, adc_busy, adc_data,
    output rx_rinc, tx_wdata, tx_winc, adc_start
  );

  modport slave (
    output rx_rdata, rx_rempty, tx_wfull, adc_busy, adc_data,
    input  rx_rinc, tx_wdata, tx_winc, adc_start
  );
endinterface

// File: rtl/cmd_dispatcher_pwm_bank.sv
// PWM counter and comparator bank.
//   clk, rst : clock, synchronous active-high reset
//   duty_i   : per-channel 8-bit duty values
//   en_i     : global enable, gates every output
//   pwm_o    : channel outputs, bit k = channel k
module cmd_dispatcher_pwm_bank #(
  parameter int unsigned N_PWM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_PWM-1:0][7:0] duty_i,
  input  logic                  en_i,
  output logic [N_PWM-1:0]      pwm_o
);

  logic [7:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Combinational compare so a new duty value is seen without waiting for wrap.
  always_comb begin
    pwm_o = '0;
    for (int k = 0; k < N_PWM; k++) begin
      pwm_o[k] = en_i && (cnt_q < duty_i[k]);
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Byte-command dispatcher: pops opcodes from the rx FIFO, drives PWM duty and
// enable, runs ADC samples and streams results / status bytes into the tx FIFO.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : rx FIFO read, tx FIFO write and ADC handshake (master side)
//   pwm_out_o : PWM channel outputs
//   err_o     : sticky error flag (invalid opcode, bad channel, argument timeout)
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int unsigned N_PWM       = 4,
  parameter int unsigned ADC_BYTES   = 4,
  parameter int unsigned ARG_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  cmd_dispatcher_if.master bus,
  output logic [N_PWM-1:0] pwm_out_o,
  output logic             err_o
);

  localparam int unsigned IdxW = (ADC_BYTES > 1) ? $clog2(ADC_BYTES) : 1;
  localparam int unsigned TmoW = $clog2(ARG_TIMEOUT + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(ADC_BYTES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ARG_TIMEOUT - 1);

  state_e                       state_q, state_d;
  logic                         err_q, err_d;
  logic                         pwm_on_q, pwm_on_d;
  logic [N_PWM-1:0][7:0]        duty_q, duty_d;
  logic [3:0]                   chan_q, chan_d;
  logic [TmoW-1:0]              tmo_q, tmo_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [ADC_BYTES-1:0][7:0]    shadow_q, shadow_d;

  logic       err_set, err_clr;
  logic [7:0] op;
  logic       rx_rinc, tx_winc, adc_start;
  logic [7:0] tx_wdata;

  always_comb begin
    state_d   = state_q;
    pwm_on_d  = pwm_on_q;
    duty_d    = duty_q;
    chan_d    = chan_q;
    tmo_d     = tmo_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    err_d     = err_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    rx_rinc   = 1'b0;
    tx_winc   = 1'b0;
    tx_wdata  = '0;
    adc_start = 1'b0;
    op        = bus.rx_rdata;

    unique case (state_q)
      StIdle: begin
        if (!bus.rx_rempty) begin
          rx_rinc = 1'b1;
          if (op == OpGetAdc) begin
            state_d = StAdcReq;
          end else if (op == OpPwmOn) begin
            pwm_on_d = 1'b1;
          end else if (op == OpPwmOff) begin
            pwm_on_d = 1'b0;
          end else if (op == OpGetStatus) begin
            state_d = StStatTx;
          end else if (op == OpClrErr) begin
            err_clr = 1'b1;
          end else if (is_set_pwm(op) && (32'(op[3:0]) < N_PWM)) begin
            chan_d  = op[3:0];
            tmo_d   = '0;
            state_d = StArg;
          end else begin
            // Covers unknown opcodes and SET_PWM to a missing channel; the
            // argument byte of the latter is left queued as the next opcode.
            err_set = 1'b1;
          end
        end
      end

      StArg: begin
        if (!bus.rx_rempty) begin
          rx_rinc = 1'b1;
          for (int k = 0; k < N_PWM; k++) begin
            if (chan_q == 4'(k)) duty_d[k] = op;
          end
          state_d = StIdle;
        end else if (tmo_q == TmoLast) begin
          err_set = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      StAdcReq: begin
        adc_start = 1'b1;
        if (bus.adc_busy) state_d = StAdcWait;
      end

      StAdcWait: begin
        if (!bus.adc_busy) begin
          shadow_d = bus.adc_data;
          idx_d    = '0;
          state_d  = StAdcTx;
        end
      end

      StAdcTx: begin
        tx_wdata = shadow_q[idx_q];
        if (!bus.tx_wfull) begin
          tx_winc = 1'b1;
          if (idx_q == IdxLast) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      StStatTx: begin
        tx_wdata = status_byte(err_q, pwm_on_q);
        if (!bus.tx_wfull) begin
          tx_winc = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // A new error wins over a clear in the same cycle.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    // Strobes are quiet for the whole reset cycle, whatever state is held.
    if (rst) begin
      rx_rinc   = 1'b0;
      tx_winc   = 1'b0;
      tx_wdata  = '0;
      adc_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      err_q    <= 1'b0;
      pwm_on_q <= 1'b0;
      duty_q   <= '0;
      chan_q   <= '0;
      tmo_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      pwm_on_q <= pwm_on_d;
      duty_q   <= duty_d;
      chan_q   <= chan_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.rx_rinc   = rx_rinc;
  assign bus.tx_winc   = tx_winc;
  assign bus.tx_wdata  = tx_wdata;
  assign bus.adc_start = adc_start;
  assign err_o         = err_q;

  cmd_dispatcher_pwm_bank #(
    .N_PWM(N_PWM)
  ) u_pwm_bank (
    .clk   (clk),
    .rst   (rst),
    .duty_i(duty_q),
    .en_i  (pwm_on_q),
    .pwm_o (pwm_out_o)
  );

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Scoreboard bench for cmd_dispatcher: stimulus tasks push expected tx bytes
// into a queue while a monitor pops and compares on every observed tx push.
module tb_cmd_dispatcher;

  localparam int unsigned NPwm       = 4;
  localparam int unsigned AdcBytes   = 4;
  localparam int unsigned ArgTimeout = 16;
  localparam int unsigned DW         = 8 * AdcBytes;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NPwm-1:0] pwm_out;
  logic            err;

  cmd_dispatcher_if #(.AdcBytes(AdcBytes)) bus ();

  cmd_dispatcher #(
    .N_PWM      (NPwm),
    .ADC_BYTES  (AdcBytes),
    .ARG_TIMEOUT(ArgTimeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pwm_out_o(pwm_out),
    .err_o    (err)
  );

  initial forever #5 clk = ~clk;

  // Environment-driven interface signals.
  logic          rx_rempty_r = 1'b1;
  logic [7:0]    rx_rdata_r  = 8'h00;
  logic          tx_wfull_r  = 1'b0;
  logic          adc_busy_r  = 1'b0;
  logic [DW-1:0] adc_data_r  = '0;

  assign bus.rx_rempty = rx_rempty_r;
  assign bus.rx_rdata  = rx_rdata_r;
  assign bus.tx_wfull  = tx_wfull_r;
  assign bus.adc_busy  = adc_busy_r;
  assign bus.adc_data  = adc_data_r;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]    rx_q[$];
  logic [7:0]    exp_q[$];
  logic [DW-1:0] adc_vals[$];
  int            wfull_mode = 0;  // 0 never full, 1 every other cycle, 2 random
  int            adc_len    = 10;
  int            adc_cnt    = 0;
  int            tx_count   = 0;

  // Reference model of the architectural state.
  logic       m_err    = 1'b0;
  logic       m_pwm_on = 1'b0;
  logic [7:0] m_duty[NPwm];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
    end
  endtask

  // Issue one command and record its effect and any response bytes.
  task automatic do_cmd(input logic [7:0] op, input logic [7:0] arg, input logic [DW-1:0] adcv);
    int k;
    @(posedge clk);
    #1;
    rx_q.push_back(op);
    k = int'(op[3:0]);
    if (op == 8'h01) begin
      adc_vals.push_back(adcv);
      for (int b = 0; b < AdcBytes; b++) exp_q.push_back(adcv[8*b +: 8]);
    end else if (op[7:4] == 4'h1) begin
      if (k < NPwm) begin
        rx_q.push_back(arg);
        m_duty[k] = arg;
      end else begin
        m_err = 1'b1;
      end
    end else if (op == 8'h20) begin
      m_pwm_on = 1'b1;
    end else if (op == 8'h21) begin
      m_pwm_on = 1'b0;
    end else if (op == 8'h30) begin
      exp_q.push_back({6'b0, m_err, m_pwm_on});
    end else if (op == 8'h31) begin
      m_err = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic drain();
    int budget = 4000;
    while ((rx_q.size() != 0 || exp_q.size() != 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("drain_pending", rx_q.size() + exp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // Count high cycles over one full counter period per channel.
  task automatic measure_pwm(input string tag);
    int cnt[NPwm];
    for (int k = 0; k < NPwm; k++) cnt[k] = 0;
    repeat (256) begin
      @(negedge clk);
      for (int k = 0; k < NPwm; k++) if (pwm_out[k]) cnt[k]++;
    end
    for (int k = 0; k < NPwm; k++) begin
      check($sformatf("%s_pwm%0d_high", tag, k), cnt[k],
            m_pwm_on ? {24'b0, m_duty[k]} : 32'd0);
    end
  endtask

  initial begin
    int          base;
    int          budget;
    logic [DW-1:0] v;

    for (int k = 0; k < NPwm; k++) m_duty[k] = 8'h00;

    fork
      begin : rx_fifo
        logic pop_s;
        forever begin
          @(posedge clk);
          pop_s = bus.rx_rinc;
          #1;
          if (pop_s) begin
            n_cmp++;
            if (rx_q.size() == 0) begin
              n_fail++;
              $display("FAIL rx_pop_empty: got pop, expected no pop from empty FIFO");
            end else begin
              void'(rx_q.pop_front());
            end
          end
          #1;
          rx_rempty_r = (rx_q.size() == 0);
          rx_rdata_r  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
      end
      begin : tx_full_gen
        forever begin
          @(posedge clk);
          #1;
          if (wfull_mode == 0)      tx_wfull_r = 1'b0;
          else if (wfull_mode == 1) tx_wfull_r = ~tx_wfull_r;
          else                      tx_wfull_r = 1'($urandom_range(0, 1));
        end
      end
      begin : adc_model
        logic st_s;
        forever begin
          @(posedge clk);
          st_s = bus.adc_start;
          #1;
          if (adc_cnt > 0) begin
            adc_cnt--;
            if (adc_cnt == 0) adc_busy_r = 1'b0;
          end else if (st_s && !adc_busy_r) begin
            n_cmp++;
            if (adc_vals.size() == 0) begin
              n_fail++;
              $display("FAIL adc_start_unexpected: got adc_start, expected none");
            end else begin
              adc_data_r = adc_vals.pop_front();
            end
            adc_busy_r = 1'b1;
            adc_cnt    = adc_len;
          end
        end
      end
      begin : tx_monitor
        forever begin
          @(negedge clk);
          if (bus.tx_winc) begin
            tx_count++;
            check("tx_winc_while_full", {31'b0, bus.tx_wfull}, 32'd0);
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL tx_unexpected: got 0x%02h, expected no byte", bus.tx_wdata);
            end else begin
              check("tx_byte", {24'b0, bus.tx_wdata}, {24'b0, exp_q.pop_front()});
            end
          end
        end
      end
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rx_rinc", {31'b0, bus.rx_rinc}, 32'd0);
    check("rst_tx_winc", {31'b0, bus.tx_winc}, 32'd0);
    check("rst_adc_start", {31'b0, bus.adc_start}, 32'd0);
    check("rst_tx_wdata", {24'b0, bus.tx_wdata}, 32'd0);
    check("rst_pwm_out", {28'b0, pwm_out}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Channel 1 at half duty.
    do_cmd(8'h11, 8'h80, '0);
    do_cmd(8'h20, 8'h00, '0);
    drain();
    measure_pwm("half");

    // Duty limits plus a mid value on channel 2.
    do_cmd(8'h10, 8'hFF, '0);
    do_cmd(8'h12, 8'h55, '0);
    do_cmd(8'h13, 8'h00, '0);
    drain();
    measure_pwm("limits");

    // ADC read, free-flowing then with tx_wfull toggling.
    adc_len    = 10;
    wfull_mode = 0;
    do_cmd(8'h01, 8'h00, 32'h0403_0201);
    drain();
    wfull_mode = 1;
    do_cmd(8'h01, 8'h00, 32'h0403_0201);
    drain();
    wfull_mode = 0;

    // Argument timeout on channel 2.
    do_cmd(8'h21, 8'h00, '0);
    drain();
    @(posedge clk);
    #1 rx_q.push_back(8'h12);
    budget = 100;
    @(posedge clk);
    while (!bus.rx_rinc && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("arg_opcode_popped", {31'b0, bus.rx_rinc}, 32'd1);
    repeat (ArgTimeout - 1) @(posedge clk);
    @(negedge clk);
    check("arg_err_before_timeout", {31'b0, err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("arg_err_at_timeout", {31'b0, err}, 32'd1);
    m_err = 1'b1;
    do_cmd(8'h30, 8'h00, '0);
    drain();
    do_cmd(8'h20, 8'h00, '0);
    drain();
    measure_pwm("timeout");

    // Invalid opcode, then clear and status.
    do_cmd(8'h21, 8'h00, '0);
    do_cmd(8'h7F, 8'h00, '0);
    drain();
    check("invalid_err", {31'b0, err}, 32'd1);
    do_cmd(8'h31, 8'h00, '0);
    do_cmd(8'h30, 8'h00, '0);
    drain();
    check("cleared_err", {31'b0, err}, 32'd0);

    // SET_PWM to a missing channel: next byte is an opcode.
    do_cmd(8'h1F, 8'h00, '0);
    do_cmd(8'h20, 8'h00, '0);
    drain();
    check("bad_chan_err", {31'b0, err}, 32'd1);
    do_cmd(8'h30, 8'h00, '0);
    drain();

    // Reset in the middle of an ADC result stream.
    adc_len = 10;
    base    = tx_count;
    do_cmd(8'h01, 8'h00, 32'hDDCC_BBAA);
    budget = 200;
    while (tx_count < base + 2 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check("mid_tx_bytes_seen", tx_count - base, 2);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx_winc", {31'b0, bus.tx_winc}, 32'd0);
    check("rst_mid_tx_wdata", {24'b0, bus.tx_wdata}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_winc", {31'b0, bus.tx_winc}, 32'd0);
    check("post_rst_adc_start", {31'b0, bus.adc_start}, 32'd0);
    check("post_rst_pwm_out", {28'b0, pwm_out}, 32'd0);
    check("post_rst_err", {31'b0, err}, 32'd0);
    check("abandoned_bytes", exp_q.size(), 2);
    exp_q.delete();
    m_err    = 1'b0;
    m_pwm_on = 1'b0;
    for (int k = 0; k < NPwm; k++) m_duty[k] = 8'h00;
    do_cmd(8'h01, 8'h00, 32'h1234_5678);
    drain();

    // Randomized command stream.
    wfull_mode = 2;
    for (int i = 0; i < 80; i++) begin
      int sel;
      logic [7:0] op;
      sel     = int'($urandom_range(0, 7));
      adc_len = int'($urandom_range(1, 12));
      for (int b = 0; b < AdcBytes; b++) v[8*b +: 8] = 8'($urandom);
      unique case (sel)
        0:       op = 8'h01;
        1:       op = 8'h10 + 8'($urandom_range(0, NPwm - 1));
        2:       op = 8'h20;
        3:       op = 8'h21;
        4:       op = 8'h30;
        5:       op = 8'h31;
        6:       op = 8'($urandom);
        default: op = 8'h10 + 8'($urandom_range(NPwm, 15));
      endcase
      do_cmd(op, 8'($urandom), v);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(posedge clk);
    end
    drain();
    check("random_err", {31'b0, err}, {31'b0, m_err});
    do_cmd(8'h20, 8'h00, '0);
    drain();
    measure_pwm("random");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_dispatcher.md
CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

Interface
REQ-001 Parameter N_PWM, default 4: number of PWM channels (1..16).
REQ-002 Parameter ADC_BYTES, default 4: number of ADC result bytes returned per sample (1..8).
REQ-003 Parameter ARG_TIMEOUT, default 65535: idle cycles allowed while waiting for an argument byte.
REQ-004 clk  in  1  single system clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx_rdata  in  8  rx FIFO head byte (first-word-fall-through), valid while rx_rempty=0.
REQ-007 rx_rempty  in  1  rx FIFO empty.
REQ-008 rx_rinc  out  1  pop rx FIFO, one byte per cycle asserted.
REQ-009 tx_wdata  out  8  byte to tx FIFO.
REQ-010 tx_winc  out  1  push tx_wdata; asserted only when tx_wfull=0.
REQ-011 tx_wfull  in  1  tx FIFO full.
REQ-012 adc_start  out  1  sample request to ADC interface.
REQ-013 adc_busy  in  1  ADC interface busy.
REQ-014 adc_data  in  8*ADC_BYTES  ADC result, valid after busy falls.
REQ-015 pwm_out  out  N_PWM  PWM outputs, bit k = channel k.
REQ-016 err  out  1  sticky error flag.

Function
REQ-017 Opcodes: 0x01 GET_ADC; 0x10+k SET_PWM channel k (k<N_PWM, one argument byte); 0x20 PWM_ON; 0x21 PWM_OFF; 0x30 GET_STATUS; 0x31 CLR_ERR; anything else is invalid.
REQ-018 States: IDLE, ARG, ADC_REQ, ADC_WAIT, ADC_TX, STAT_TX.
REQ-019 IDLE: when rx_rempty=0, assert rx_rinc that cycle, latch rx_rdata as opcode, and decode it in the same cycle.
REQ-020 Transitions out of IDLE: PWM_ON, PWM_OFF and CLR_ERR apply in one cycle and stay in IDLE; SET_PWM goes to ARG; GET_ADC goes to ADC_REQ; GET_STATUS goes to STAT_TX; an invalid opcode sets err and stays in IDLE.
REQ-021 ARG: when rx_rempty=0, pop the byte, write it to duty[k] on the next edge, and return to IDLE.
REQ-022 ARG timeout: an internal counter clears on entry to ARG; if ARG_TIMEOUT consecutive cycles pass with rx_rempty=1, set err, leave duty unchanged, and return to IDLE.
REQ-023 ADC_REQ: hold adc_start=1 until adc_busy=1 is sampled, then go to ADC_WAIT.
REQ-024 ADC_WAIT: on adc_busy=0, latch adc_data into a shadow register, clear the byte index, and go to ADC_TX.
REQ-025 ADC_TX: in each cycle with tx_wfull=0, push shadow byte[index], LSB byte first; after byte ADC_BYTES-1 return to IDLE.
REQ-026 ADC_TX stall: while tx_wfull=1, hold the index and keep tx_winc=0; no byte is lost or duplicated.
REQ-027 STAT_TX: push one byte {5'b0, ADC_BYTES-independent 0, err, pwm_on} when tx_wfull=0, then return to IDLE.
REQ-028 Only IDLE and ARG assert rx_rinc; bytes arriving during ADC or status states stay queued.
REQ-029 PWM: a free-running 8-bit counter drives all channels; pwm_out[k] = (cnt < duty[k]) AND pwm_on.
REQ-030 PWM limits: duty 0x00 gives a constant low output; 0xFF gives 255 of every 256 cycles high.
REQ-031 A duty write takes effect in the cycle after the write edge, with no wait for counter wrap.
REQ-032 SET_PWM with k>=N_PWM is invalid: set err and consume no argument byte.
REQ-033 A CLR_ERR that coincides with a new error condition leaves err set; only the command itself is cleared.

Reset
REQ-034 While rst=1 (synchronous, active-high): state goes to IDLE; duty[*], pwm_on, err and cnt clear to 0; rx_rinc, tx_winc and adc_start are held 0; tx_wdata goes to 0x00.
REQ-035 Reset mid-operation (ARG, ADC_*, *_TX) abandons the transaction immediately, pushes no partial bytes, and resets the timeout and index counters.

Structure
REQ-036 Opcode constants, state encoding and the status-bit positions live in the shared package cmd_pkg (.vh include), also used by host-side sims.
REQ-037 The PWM counter and comparator bank is one sub-module, pwm_bank #(N_PWM), with inputs clk, rst, duty vector and enable.

Verification
REQ-038 Send bytes 0x11, 0x80, then 0x20: by the following cycle duty[1]=0x80, and pwm_out[1] is high for 128 of every 256 cycles.
REQ-039 Send 0x01 with an ADC model that raises busy for 10 cycles and returns 0x0403_0201: tx receives 0x01,0x02,0x03,0x04 in order; repeat with tx_wfull pulsed every other cycle for identical bytes.
REQ-040 Send 0x12 only (ARG_TIMEOUT=16): after 16 empty cycles err=1, duty[2] is unchanged, and the state is IDLE; then 0x30 returns status 0x02.
REQ-041 Send 0x7F, then 0x31, then 0x30: err rises after the first byte, and the status byte returned is 0x00.
REQ-042 Assert rst for one cycle during ADC_TX after 2 bytes: no further tx_winc, all outputs are 0 the next cycle, and a subsequent GET_ADC returns the full ADC_BYTES bytes.
REQ-043 Send 0x1F with N_PWM=4: err=1 and the next byte is decoded as an opcode.
